seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered successor to the combinational 32-bit ALU in the RISC datapath.
- Generic WIDTH; registered result and flags (C, N, V, Z); valid/ready input handshake.
- Single-cycle ops complete in 1 cycle.
- Adds iterative multi-cycle MUL, UDIV and UREM, executed by a shift-add/restoring sub-unit.
- Sits in the EX stage; the control unit stalls on in_ready=0.

Parameters:
- WIDTH, 32, operand/result width (>=8, power of 2).
- OP_W, 5, opcode width.
- SH_W, $clog2(WIDTH), shift-amount bits taken from B.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  unit can accept this cycle.
- op  in  OP_W  operation code.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  input carry.
- out_valid  out  1  one-cycle pulse: result and flags updated.
- result  out  WIDTH  registered result, held until the next completion.
- c_flag, n_flag, v_flag, z_flag  out  1 each  registered condition codes, held like result.
- dz  out  1  divide-by-zero on the last UDIV/UREM, held.
- err  out  1  illegal opcode on the last op, held.

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; result=0; all flags, dz and err = 0.
- Reset mid-operation aborts the operation with no out_valid.
- Accept occurs when in_valid && in_ready; operands and op are latched on that edge.
- Opcodes and single-cycle ops (out_valid on the edge after accept, i.e. latency 1):
  - 0 ADD a+b; 1 ADC a+b+cin; 2 SUB a-b; 3 SBC a-b-!cin.
  - 4 AND; 5 OR; 6 XOR; 7 BIC a&~b; 8 MOV b; 9 MVN ~b.
  - 10 LSL, 11 LSR, 12 ASR: a shifted by b[SH_W-1:0].
- Multi-cycle ops: 13 MUL (low WIDTH bits of the product), 14 UDIV quotient, 15 UREM remainder.
- Opcodes 16..(2^OP_W - 1) are illegal: result=0, err=1, C=V=0, Z=1, latency 1.
- Flags:
  - Z = (result==0); N = result[WIDTH-1] for every op.
  - Add ops: C = carry-out; V = signed overflow (same-sign operands, different-sign result).
  - Sub ops: C = NOT borrow; V = signed overflow (operand signs differ, result sign != a sign).
  - Logic/MOV/MVN: C=0, V=0.
  - Shifts: C = last bit shifted out (0 when the shift amount is 0); V=0.
  - MUL/DIV: C=0, V=0.
- FSM states:
  - IDLE: in_ready=1. A single-cycle op is computed and registered directly from IDLE, and back-to-back accepts are allowed every cycle. A multi-cycle op goes to ITER with count=WIDTH.
  - ITER: in_ready=0. One multiply/divide step per cycle; count decrements; at count==1 go to FIN.
  - FIN: writes result/flags, out_valid=1, in_ready=0, then returns to IDLE.
  - Total latency for multi-cycle ops: WIDTH+1 cycles from accept to out_valid.
- Divide by zero: not iterated; goes straight to FIN. UDIV returns all-ones, UREM returns a, dz=1.
- dz is cleared by any other completion.
- Multi-cycle arithmetic is unsigned; the internal accumulator is 2*WIDTH bits.
- in_valid during ITER/FIN is ignored (not accepted); the op must be held by the producer.

Decomposition:
- Package seq_alu_pkg holds:
  - opcode localparams (OP_ADD..OP_UREM, OP_LAST_LEGAL=15);
  - state encoding (ST_IDLE, ST_ITER, ST_FIN);
  - helper function is_multicycle(op).
- Sub-module seq_alu_muldiv: iterative shift-add multiplier / restoring divider with start, step-count and busy handshake to the parent.
- The top level holds the single-cycle datapath, flag logic and FSM.

Test Plan (WIDTH=32):
- ADD overflow: a=0x7FFFFFFD, b=2 -> 0x7FFFFFFF, N=V=C=Z=0. Then a=0x7FFFFFFF, b=2 -> 0x80000001, N=1, V=1, C=0. out_valid 1 cycle after each accept.
- SUB: a=0x80000002, b=2 -> 0x80000000, N=1, C=1, V=0. Then a=0x80000000, b=2 -> 0x7FFFFFFE, V=1, C=1, N=0.
- MUL: a=0x00010000, b=0x00010000 -> result 0, Z=1. out_valid exactly 33 cycles after accept; in_ready=0 for cycles 1..33; a held in_valid is not accepted until in_ready returns.
- Division: UDIV a=100, b=7 -> 14; UREM -> 2; UDIV b=0 -> 0xFFFFFFFF with dz=1, latency 2. A following ADD clears dz.
- Reset mid-MUL at cycle 10 -> next cycle in_ready=1, out_valid=0, result=0. An ADD 3+4 accepted next yields 7.
- Streaming and edge cases:
  - ADD, AND, LSL (a=0x80000001, b=1 -> 0x00000002, C=1) presented with in_valid held: accepted on consecutive cycles with out_valid high 3 cycles.
  - op=20 -> result 0, err=1, Z=1.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcodes, FSM states and opcode classification for seq_alu
package seq_alu_pkg;
   localparam int unsigned OP_ADD        = 0;
   localparam int unsigned OP_ADC        = 1;
   localparam int unsigned OP_SUB        = 2;
   localparam int unsigned OP_SBC        = 3;
   localparam int unsigned OP_AND        = 4;
   localparam int unsigned OP_OR         = 5;
   localparam int unsigned OP_XOR        = 6;
   localparam int unsigned OP_BIC        = 7;
   localparam int unsigned OP_MOV        = 8;
   localparam int unsigned OP_MVN        = 9;
   localparam int unsigned OP_LSL        = 10;
   localparam int unsigned OP_LSR        = 11;
   localparam int unsigned OP_ASR        = 12;
   localparam int unsigned OP_MUL        = 13;
   localparam int unsigned OP_UDIV       = 14;
   localparam int unsigned OP_UREM       = 15;
   localparam int unsigned OP_LAST_LEGAL = 15;

   typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_FIN} state_t;

   function automatic logic is_multicycle(input int unsigned code);
      return code >= OP_MUL && code <= OP_LAST_LEGAL;
   endfunction
endpackage

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: shift-add multiplier and restoring divider, one bit per step
module seq_alu_muldiv
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               div,
   input  logic               step,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] acc_next
);
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   d;
   logic               div_q;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     diff;

   // multiply: add the multiplicand into the upper half when the low bit is set, then shift right
   assign sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, d} : '0);
   // divide: shift the next dividend bit into the remainder and try subtracting the divisor
   assign rem_sh = acc[2*WIDTH-1:WIDTH-1];
   assign diff   = rem_sh - {1'b0, d};

   // next accumulator value; the parent samples it on the final step to avoid an extra cycle
   always_comb begin
      acc_next = div_q ? (diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                      : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                       : {sum, acc[WIDTH-1:1]};
   end

   // load operands on start, then advance one step per enabled cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         acc   <= '0;
         d     <= '0;
         div_q <= 1'b0;
      end else if (start) begin
         acc   <= {{WIDTH{1'b0}}, div ? a : b};
         d     <= div ? b : a;
         div_q <= div;
      end else if (step) begin
         acc <= acc_next;
      end
   end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with iterative multiply/divide and a valid/ready input handshake
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int OP_W  = 5,
   parameter int SH_W  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             c_flag,
   output logic             n_flag,
   output logic             v_flag,
   output logic             z_flag,
   output logic             dz,
   output logic             err
);
   localparam int CW = SH_W + 1;

   state_t             state;
   logic [CW-1:0]      count;
   logic [OP_W-1:0]    op_q;
   logic [WIDTH-1:0]   a_q;
   logic               zero_div;
   logic               accept;
   logic               multi;
   logic               div_op;
   logic               div0;
   logic               add_in;
   logic               sub_in;
   logic [SH_W-1:0]    sh;
   logic [WIDTH:0]     sum_ext;
   logic [WIDTH:0]     dif_ext;
   logic [WIDTH:0]     lsl_ext;
   logic [WIDTH:0]     lsr_ext;
   logic [WIDTH:0]     asr_ext;
   logic [WIDTH-1:0]   s_res;
   logic               s_c;
   logic               s_v;
   logic               s_err;
   logic [WIDTH-1:0]   m_res;
   logic [2*WIDTH-1:0] acc_next;

   assign accept  = in_valid && in_ready;
   assign multi   = is_multicycle(32'(op));
   assign div_op  = op == OP_W'(OP_UDIV) || op == OP_W'(OP_UREM);
   assign div0    = div_op && b == '0;
   assign sh      = b[SH_W-1:0];
   assign add_in  = op == OP_W'(OP_ADC) && cin;
   assign sub_in  = op != OP_W'(OP_SBC) || cin;
   assign sum_ext = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(add_in);
   assign dif_ext = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(sub_in);
   // the extra bit of each shift catches the last bit shifted out (zero for a zero shift)
   assign lsl_ext = {1'b0, a} << sh;
   assign lsr_ext = {a, 1'b0} >> sh;
   assign asr_ext = $signed({a, 1'b0}) >>> sh;

   // division by zero bypasses the iterator and returns all-ones or the dividend
   assign m_res = zero_div ? (op_q == OP_W'(OP_UDIV) ? '1 : a_q)
                           : (op_q == OP_W'(OP_UREM) ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0]);

   seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk      (clk),
      .reset    (reset),
      .start    (accept && multi && !div0),
      .div      (div_op),
      .step     (state == ST_ITER && !zero_div),
      .a        (a),
      .b        (b),
      .acc_next (acc_next)
   );

   // single-cycle result, carry and overflow straight from the presented operands
   always_comb begin
      s_res = '0;
      s_c   = 1'b0;
      s_v   = 1'b0;
      s_err = 1'b0;
      case (op)
         OP_W'(OP_ADD), OP_W'(OP_ADC): begin
            s_res = sum_ext[WIDTH-1:0];
            s_c   = sum_ext[WIDTH];
            s_v   = a[WIDTH-1] == b[WIDTH-1] && sum_ext[WIDTH-1] != a[WIDTH-1];
         end
         OP_W'(OP_SUB), OP_W'(OP_SBC): begin
            s_res = dif_ext[WIDTH-1:0];
            s_c   = dif_ext[WIDTH];
            s_v   = a[WIDTH-1] != b[WIDTH-1] && dif_ext[WIDTH-1] != a[WIDTH-1];
         end
         OP_W'(OP_AND): s_res = a & b;
         OP_W'(OP_OR):  s_res = a | b;
         OP_W'(OP_XOR): s_res = a ^ b;
         OP_W'(OP_BIC): s_res = a & ~b;
         OP_W'(OP_MOV): s_res = b;
         OP_W'(OP_MVN): s_res = ~b;
         OP_W'(OP_LSL): {s_c, s_res} = lsl_ext;
         OP_W'(OP_LSR): {s_res, s_c} = lsr_ext;
         OP_W'(OP_ASR): {s_res, s_c} = asr_ext;
         OP_W'(OP_MUL), OP_W'(OP_UDIV), OP_W'(OP_UREM): begin
         end
         default: s_err = 1'b1;
      endcase
   end

   // control FSM with registered handshake, result and condition codes
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         c_flag    <= 1'b0;
         n_flag    <= 1'b0;
         v_flag    <= 1'b0;
         z_flag    <= 1'b0;
         dz        <= 1'b0;
         err       <= 1'b0;
         count     <= '0;
         op_q      <= '0;
         a_q       <= '0;
         zero_div  <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept && multi) begin
                  state    <= ST_ITER;
                  in_ready <= 1'b0;
                  op_q     <= op;
                  a_q      <= a;
                  zero_div <= div0;
                  count    <= div0 ? CW'(1) : CW'(WIDTH);
               end else if (accept) begin
                  out_valid <= 1'b1;
                  result    <= s_res;
                  c_flag    <= s_c;
                  v_flag    <= s_v;
                  n_flag    <= s_res[WIDTH-1];
                  z_flag    <= s_res == '0;
                  dz        <= 1'b0;
                  err       <= s_err;
               end
            end
            ST_ITER: begin
               count <= count - CW'(1);
               if (count == CW'(1)) begin
                  state     <= ST_FIN;
                  out_valid <= 1'b1;
                  result    <= m_res;
                  c_flag    <= 1'b0;
                  v_flag    <= 1'b0;
                  n_flag    <= m_res[WIDTH-1];
                  z_flag    <= m_res == '0;
                  dz        <= zero_div;
                  err       <= 1'b0;
               end
            end
            ST_FIN: begin
               state    <= ST_IDLE;
               in_ready <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random checks of seq_alu against a behavioural arithmetic model
module tb_seq_alu;
   typedef struct {
      logic [31:0] res;
      logic        c;
      logic        n;
      logic        v;
      logic        z;
      logic        dz;
      logic        err;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  op = '0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        cin = 1'b0;
   logic        out_valid;
   logic [31:0] result;
   logic        c_flag;
   logic        n_flag;
   logic        v_flag;
   logic        z_flag;
   logic        dz;
   logic        err;
   int          errors = 0;
   int          checks = 0;

   seq_alu #(.WIDTH(32), .OP_W(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .result    (result),
      .c_flag    (c_flag),
      .n_flag    (n_flag),
      .v_flag    (v_flag),
      .z_flag    (z_flag),
      .dz        (dz),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic exp_t ref_model(input int code, input logic [31:0] x, input logic [31:0] y, input logic ci);
      exp_t              e;
      longint unsigned   ux;
      longint unsigned   uy;
      longint unsigned   ur;
      longint            sr;
      longint            k;
      int                sh;
      ux    = {32'd0, x};
      uy    = {32'd0, y};
      sh    = int'(y[4:0]);
      e.res = '0;
      e.c   = 1'b0;
      e.v   = 1'b0;
      e.dz  = 1'b0;
      e.err = 1'b0;
      e.lat = 1;
      case (code)
         0, 1: begin
            k     = (code == 1 && ci) ? 64'sd1 : 64'sd0;
            ur    = ux + uy + longint'(k);
            sr    = longint'($signed(x)) + longint'($signed(y)) + k;
            e.res = ur[31:0];
            e.c   = ur[32];
            e.v   = sr != longint'($signed(sr[31:0]));
         end
         2, 3: begin
            k     = (code == 3 && !ci) ? 64'sd1 : 64'sd0;
            ur    = ux - uy - longint'(k);
            sr    = longint'($signed(x)) - longint'($signed(y)) - k;
            e.res = ur[31:0];
            e.c   = ux >= uy + longint'(k);
            e.v   = sr != longint'($signed(sr[31:0]));
         end
         4: e.res = x & y;
         5: e.res = x | y;
         6: e.res = x ^ y;
         7: e.res = x & ~y;
         8: e.res = y;
         9: e.res = ~y;
         10: begin
            e.res = x << sh;
            e.c   = sh == 0 ? 1'b0 : x[32-sh];
         end
         11: begin
            e.res = x >> sh;
            e.c   = sh == 0 ? 1'b0 : x[sh-1];
         end
         12: begin
            e.res = $signed(x) >>> sh;
            e.c   = sh == 0 ? 1'b0 : x[sh-1];
         end
         13: begin
            ur    = ux * uy;
            e.res = ur[31:0];
            e.lat = 33;
         end
         14, 15: begin
            if (y == 0) begin
               e.res = code == 14 ? 32'hFFFF_FFFF : x;
               e.dz  = 1'b1;
               e.lat = 2;
            end else begin
               ur    = code == 14 ? ux / uy : ux % uy;
               e.res = ur[31:0];
               e.lat = 33;
            end
         end
         default: e.err = 1'b1;
      endcase
      e.n = e.res[31];
      e.z = e.res == 0;
      return e;
   endfunction

   task automatic do_op(input int code, input logic [31:0] x, input logic [31:0] y, input logic ci, input string tag);
      exp_t e;
      int   lat;
      int   busy_hits;
      e = ref_model(code, x, y, ci);
      for (int i = 0; i < 100 && !in_ready; i++) tick();
      chk({tag, " ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      op       = 5'(code);
      a        = x;
      b        = y;
      cin      = ci;
      tick();
      in_valid  = 1'b0;
      op        = 5'($urandom_range(0, 31));
      a         = $urandom;
      b         = $urandom;
      cin       = 1'($urandom_range(0, 1));
      lat       = 1;
      busy_hits = 0;
      while (!out_valid && lat < 100) begin
         if (in_ready) busy_hits++;
         tick();
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'(e.lat));
      chk({tag, " result"}, result, e.res);
      chk({tag, " cnvz"}, {28'd0, c_flag, n_flag, v_flag, z_flag}, {28'd0, e.c, e.n, e.v, e.z});
      chk({tag, " dz/err"}, {30'd0, dz, err}, {30'd0, e.dz, e.err});
      if (e.lat > 1) begin
         chk({tag, " ready low while busy"}, 32'(busy_hits), 32'd0);
         chk({tag, " ready low at completion"}, 32'(in_ready), 32'd0);
      end
      tick();
      chk({tag, " pulse"}, 32'(out_valid), 32'd0);
      chk({tag, " held"}, result, e.res);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      exp_t e;
      int   lat;
      int   busy_hits;
      int   code;
      logic [31:0] x;
      logic [31:0] y;
      tick();
      tick();
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset result", result, 32'd0);
      chk("reset cnvz", {28'd0, c_flag, n_flag, v_flag, z_flag}, 32'd0);
      chk("reset dz/err", {30'd0, dz, err}, 32'd0);
      reset = 1'b0;
      tick();
      do_op(0, 32'h7FFF_FFFD, 32'd2, 1'b0, "add no ovf");
      do_op(0, 32'h7FFF_FFFF, 32'd2, 1'b0, "add ovf");
      do_op(2, 32'h8000_0002, 32'd2, 1'b0, "sub neg");
      do_op(2, 32'h8000_0000, 32'd2, 1'b0, "sub ovf");
      do_op(1, 32'hFFFF_FFFF, 32'd0, 1'b1, "adc carry");
      do_op(3, 32'd5, 32'd5, 1'b0, "sbc borrow");
      do_op(12, 32'h8000_0010, 32'd4, 1'b0, "asr");
      do_op(10, 32'h1234_5678, 32'd0, 1'b0, "lsl zero");
      do_op(14, 32'd100, 32'd7, 1'b0, "udiv");
      do_op(15, 32'd100, 32'd7, 1'b0, "urem");
      do_op(14, 32'd100, 32'd0, 1'b0, "udiv by zero");
      do_op(0, 32'd1, 32'd1, 1'b0, "add clears dz");
      do_op(15, 32'hDEAD_BEEF, 32'd0, 1'b0, "urem by zero");
      do_op(20, 32'd9, 32'd9, 1'b0, "illegal op");
      do_op(13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mul max");
      // MUL with a following ADD held on the inputs throughout
      e        = ref_model(13, 32'h0001_0000, 32'h0001_0000, 1'b0);
      in_valid = 1'b1;
      op       = 5'd13;
      a        = 32'h0001_0000;
      b        = 32'h0001_0000;
      tick();
      op        = 5'd0;
      a         = 32'd3;
      b         = 32'd4;
      lat       = 1;
      busy_hits = 0;
      while (!out_valid && lat < 100) begin
         if (in_ready) busy_hits++;
         tick();
         lat++;
      end
      chk("mul latency", 32'(lat), 32'd33);
      chk("mul result", result, e.res);
      chk("mul z", 32'(z_flag), 32'd1);
      chk("mul busy ready", 32'(busy_hits), 32'd0);
      chk("mul fin ready", 32'(in_ready), 32'd0);
      tick();
      chk("held add not early", 32'(out_valid), 32'd0);
      chk("ready back", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("held add valid", 32'(out_valid), 32'd1);
      chk("held add result", result, 32'd7);
      // reset in the middle of a multiply
      in_valid = 1'b1;
      op       = 5'd13;
      a        = 32'h0000_1234;
      b        = 32'h0000_5678;
      tick();
      in_valid = 1'b0;
      repeat (9) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort in_ready", 32'(in_ready), 32'd1);
      chk("abort out_valid", 32'(out_valid), 32'd0);
      chk("abort result", result, 32'd0);
      busy_hits = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) busy_hits++;
         tick();
      end
      chk("abort no late valid", 32'(busy_hits), 32'd0);
      do_op(0, 32'd3, 32'd4, 1'b0, "add after reset");
      // back-to-back single-cycle ops with in_valid held high
      in_valid = 1'b1;
      op       = 5'd0;
      a        = 32'h0000_00F0;
      b        = 32'h0000_000F;
      tick();
      chk("stream add valid", 32'(out_valid), 32'd1);
      chk("stream add result", result, 32'h0000_00FF);
      op = 5'd4;
      a  = 32'hFF00_FF00;
      b  = 32'h0FF0_0FF0;
      tick();
      chk("stream and valid", 32'(out_valid), 32'd1);
      chk("stream and result", result, 32'h0F00_0F00);
      op = 5'd10;
      a  = 32'h8000_0001;
      b  = 32'd1;
      tick();
      in_valid = 1'b0;
      chk("stream lsl valid", 32'(out_valid), 32'd1);
      chk("stream lsl result", result, 32'h0000_0002);
      chk("stream lsl cnvz", {28'd0, c_flag, n_flag, v_flag, z_flag}, 32'h8);
      tick();
      chk("stream end", 32'(out_valid), 32'd0);
      // random operations
      for (int k = 0; k < 60; k++) begin
         code = $urandom_range(0, 19);
         x    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1000)) : 32'($urandom);
         case ($urandom_range(0, 5))
            0:       y = 32'd0;
            1:       y = 32'($urandom_range(1, 40));
            default: y = $urandom;
         endcase
         do_op(code, x, y, 1'($urandom_range(0, 1)), $sformatf("rand%0d op%0d", k, code));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
